// File: rtl/vector_coalesce.sv
// vector_coalesce: gathers 4-lane execute beats into one 256-bit vector record
// (16 x 16-bit elements, element 0 in the top bits) and passes scalars through.
// Emits one registered writeback pulse per instruction; flush drops in-flight work.
// Optional build macro VECTOR_COALESCE_VDOT_REDUCE_EN: the VDOT_OPCODE vector op
// reduces its unmasked lanes into a 16-bit scalar sum instead of a vector.
module vector_coalesce #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ELEMS = 16,
  parameter int unsigned EW    = 16
`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
  , parameter logic [3:0] VDOT_OPCODE = 4'hE
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [15:0]         in_pc,
  input  logic [15:0]         in_ins,
  input  logic [4:0]          in_vlen,
  input  logic [EW-1:0]       in_lane0,
  input  logic [EW-1:0]       in_lane1,
  input  logic [EW-1:0]       in_lane2,
  input  logic [EW-1:0]       in_lane3,
  output logic                out_valid,
  output logic [15:0]         out_pc,
  output logic [15:0]         out_ins,
  output logic                out_is_vector,
  output logic [3:0]          out_rt,
  output logic [EW-1:0]       out_sdata,
  output logic [ELEMS*EW-1:0] out_vdata,
  output logic [4:0]          out_vlen,
  output logic                busy,
  output logic                err
);

  localparam int unsigned VW = ELEMS * EW;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state, state_d;
  logic [1:0]      cnt, cnt_d, last, last_d, beat_idx;
  logic [15:0]     lat_pc, lat_pc_d, lat_ins, lat_ins_d;
  logic [4:0]      lat_vlen, lat_vlen_d, vlen_sat;
  logic [VW-1:0]   vec, vec_d, vec_masked;
  logic            start;
  logic [EW-1:0]   lanes [LANES];

  logic            out_valid_d, out_is_vector_d, busy_d, err_d;
  logic [15:0]     out_pc_d, out_ins_d;
  logic [3:0]      out_rt_d;
  logic [EW-1:0]   out_sdata_d;
  logic [VW-1:0]   out_vdata_d;
  logic [4:0]      out_vlen_d;

`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
  logic [EW-1:0]   acc, acc_d;
`endif

  assign lanes[0] = in_lane0;
  assign lanes[1] = in_lane1;
  assign lanes[2] = in_lane2;
  assign lanes[3] = in_lane3;

  // Saturate the incoming length to ELEMS
  assign vlen_sat = (in_vlen > 5'(ELEMS)) ? 5'(ELEMS) : in_vlen;

  // State, collection datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= '0;
      lat_pc        <= '0;
      lat_ins       <= '0;
      lat_vlen      <= '0;
      vec           <= '0;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_ins       <= '0;
      out_is_vector <= 1'b0;
      out_rt        <= '0;
      out_sdata     <= '0;
      out_vdata     <= '0;
      out_vlen      <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
      acc           <= '0;
`endif
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      last          <= last_d;
      lat_pc        <= lat_pc_d;
      lat_ins       <= lat_ins_d;
      lat_vlen      <= lat_vlen_d;
      vec           <= vec_d;
      out_valid     <= out_valid_d;
      out_pc        <= out_pc_d;
      out_ins       <= out_ins_d;
      out_is_vector <= out_is_vector_d;
      out_rt        <= out_rt_d;
      out_sdata     <= out_sdata_d;
      out_vdata     <= out_vdata_d;
      out_vlen      <= out_vlen_d;
      busy          <= busy_d;
      err           <= err_d;
`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
      acc           <= acc_d;
`endif
    end
  end

  // Next-state, beat placement, masking and record formation
  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    last_d          = last;
    lat_pc_d        = lat_pc;
    lat_ins_d       = lat_ins;
    lat_vlen_d      = lat_vlen;
    vec_d           = vec;
    vec_masked      = '0;
    start           = 1'b0;
    beat_idx        = cnt;
    out_valid_d     = 1'b0;
    out_pc_d        = out_pc;
    out_ins_d       = out_ins;
    out_is_vector_d = out_is_vector;
    out_rt_d        = out_rt;
    out_sdata_d     = out_sdata;
    out_vdata_d     = out_vdata;
    out_vlen_d      = out_vlen;
    err_d           = 1'b0;
    busy_d          = 1'b0;
`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
    acc_d           = acc;
`endif

    if (flush) begin
      // Flush wins: drop the partial vector and the in-cycle beat
      state_d = IDLE;
      cnt_d   = '0;
`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
      acc_d   = '0;
`endif
    end else if (in_valid) begin
      // A beat with a foreign pc while collecting abandons the partial vector
      err_d = (state == COLLECT) && (in_pc != lat_pc);
      start = (state == IDLE) || (in_pc != lat_pc);

      if (start && !in_ins[15]) begin
        out_valid_d     = 1'b1;
        out_pc_d        = in_pc;
        out_ins_d       = in_ins;
        out_is_vector_d = 1'b0;
        out_rt_d        = in_ins[3:0];
        out_sdata_d     = in_lane0;
        out_vdata_d     = '0;
        out_vlen_d      = '0;
        state_d         = IDLE;
        cnt_d           = '0;
      end else begin
        if (start) begin
          lat_pc_d   = in_pc;
          lat_ins_d  = in_ins;
          lat_vlen_d = vlen_sat;
          last_d     = (vlen_sat == 5'd0) ? 2'd0 : 2'((vlen_sat - 5'd1) >> 2);
          beat_idx   = 2'd0;
          vec_d      = '0;
`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
          acc_d      = '0;
`endif
        end

        // Place this beat's lanes into elements 4b..4b+3
        for (int e = 0; e < int'(ELEMS); e++) begin
          if ((e / int'(LANES)) == int'(beat_idx))
            vec_d[VW-1-EW*e -: EW] = lanes[e % int'(LANES)];
        end

`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
        // Running dot-product sum over unmasked lanes, modulo 2^EW
        if (lat_ins_d[15:12] == VDOT_OPCODE) begin
          for (int i = 0; i < int'(LANES); i++) begin
            if (int'(LANES) * int'(beat_idx) + i < int'(lat_vlen_d))
              acc_d = acc_d + lanes[i];
          end
        end
`endif

        // Elements at or beyond vlen read as zero
        for (int e = 0; e < int'(ELEMS); e++) begin
          if (e < int'(lat_vlen_d))
            vec_masked[VW-1-EW*e -: EW] = vec_d[VW-1-EW*e -: EW];
        end

        if (beat_idx == last_d) begin
          out_valid_d     = 1'b1;
          out_pc_d        = lat_pc_d;
          out_ins_d       = lat_ins_d;
          out_is_vector_d = 1'b1;
          out_rt_d        = lat_ins_d[3:0];
          out_sdata_d     = '0;
          out_vdata_d     = vec_masked;
          out_vlen_d      = lat_vlen_d;
`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
          if (lat_ins_d[15:12] == VDOT_OPCODE) begin
            out_is_vector_d = 1'b0;
            out_sdata_d     = acc_d;
            out_vdata_d     = '0;
          end
`endif
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = COLLECT;
          cnt_d   = beat_idx + 2'd1;
        end
      end
    end

    busy_d = (state_d == COLLECT);
  end

endmodule

// File: tb/tb_vector_coalesce.sv
// Self-checking bench for vector_coalesce: directed beats, expected writeback
// records queued at drive time and matched against each out_valid pulse.
module tb_vector_coalesce;

  logic         clk, rst, flush, in_valid;
  logic [15:0]  in_pc, in_ins;
  logic [4:0]   in_vlen;
  logic [15:0]  in_lane0, in_lane1, in_lane2, in_lane3;
  logic         out_valid, out_is_vector, busy, err;
  logic [15:0]  out_pc, out_ins, out_sdata;
  logic [3:0]   out_rt;
  logic [255:0] out_vdata;
  logic [4:0]   out_vlen;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [15:0]  pc;
    logic [15:0]  ins;
    logic         isv;
    logic [3:0]   rt;
    logic [15:0]  sdata;
    logic [255:0] vdata;
    logic [4:0]   vlen;
  } rec_t;

  rec_t sb[$];

  vector_coalesce dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_ins(in_ins), .in_vlen(in_vlen),
    .in_lane0(in_lane0), .in_lane1(in_lane1), .in_lane2(in_lane2), .in_lane3(in_lane3),
    .out_valid(out_valid), .out_pc(out_pc), .out_ins(out_ins),
    .out_is_vector(out_is_vector), .out_rt(out_rt), .out_sdata(out_sdata),
    .out_vdata(out_vdata), .out_vlen(out_vlen), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected vector: element i = base+i for i < vlen, zero elsewhere
  function automatic logic [255:0] vec_of(input int vlen, input logic [15:0] base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++)
      if (i < vlen) v[255-16*i -: 16] = base + 16'(i);
    return v;
  endfunction

  function automatic rec_t scalar_rec(input logic [15:0] pc, input logic [15:0] ins,
                                      input logic [15:0] sdata);
    rec_t r;
    r.pc = pc; r.ins = ins; r.isv = 1'b0; r.rt = ins[3:0];
    r.sdata = sdata; r.vdata = '0; r.vlen = '0;
    return r;
  endfunction

  function automatic rec_t vector_rec(input logic [15:0] pc, input logic [15:0] ins,
                                      input logic [255:0] vdata, input logic [4:0] vlen);
    rec_t r;
    r.pc = pc; r.ins = ins; r.isv = 1'b1; r.rt = ins[3:0];
    r.sdata = '0; r.vdata = vdata; r.vlen = vlen;
    return r;
  endfunction

  // One cycle of input; returns just after the capturing edge
  task automatic beat(input logic v, input logic fl, input logic [15:0] pc,
                      input logic [15:0] ins, input logic [4:0] vl,
                      input logic [15:0] l0, input logic [15:0] l1,
                      input logic [15:0] l2, input logic [15:0] l3);
    in_valid = v; flush = fl; in_pc = pc; in_ins = ins; in_vlen = vl;
    in_lane0 = l0; in_lane1 = l1; in_lane2 = l2; in_lane3 = l3;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 16'h0, 16'h0, 5'd0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 256'(out_valid), 256'(1'b0));
      end else begin
        rec_t r;
        r = sb.pop_front();
        check("rec_pc", 256'(out_pc), 256'(r.pc));
        check("rec_ins", 256'(out_ins), 256'(r.ins));
        check("rec_is_vector", 256'(out_is_vector), 256'(r.isv));
        check("rec_rt", 256'(out_rt), 256'(r.rt));
        if (r.isv) begin
          check("rec_vdata", out_vdata, r.vdata);
          check("rec_vlen", 256'(out_vlen), 256'(r.vlen));
        end else begin
          check("rec_sdata", 256'(out_sdata), 256'(r.sdata));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_ins = '0; in_vlen = '0;
    in_lane0 = '0; in_lane1 = '0; in_lane2 = '0; in_lane3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 256'(out_valid), 256'(0));
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_err", 256'(err), 256'(0));
    check("reset_vdata", out_vdata, 256'(0));
    check("reset_sdata", 256'(out_sdata), 256'(0));
    rst = 1'b0;
    idle();

    // Scalar pass-through; lanes 1-3 ignored, one-cycle pulse
    sb.push_back(scalar_rec(16'h0010, 16'h0123, 16'h00AB));
    beat(1, 0, 16'h0010, 16'h0123, 5'd0, 16'h00AB, 16'h1111, 16'h2222, 16'h3333);
    check("scalar_valid", 256'(out_valid), 256'(1));
    idle();
    check("scalar_pulse_end", 256'(out_valid), 256'(0));

    // Full 16-element vector over 4 beats
    sb.push_back(vector_rec(16'h0020, 16'h8005, vec_of(16, 16'd1), 5'd16));
    beat(1, 0, 16'h0020, 16'h8005, 5'd16, 16'd1, 16'd2, 16'd3, 16'd4);
    check("v16_busy", 256'(busy), 256'(1));
    beat(1, 0, 16'h0020, 16'h8005, 5'd0, 16'd5, 16'd6, 16'd7, 16'd8);
    beat(1, 0, 16'h0020, 16'h8005, 5'd0, 16'd9, 16'd10, 16'd11, 16'd12);
    check("v16_no_early_valid", 256'(out_valid), 256'(0));
    beat(1, 0, 16'h0020, 16'h8005, 5'd0, 16'd13, 16'd14, 16'd15, 16'd16);
    check("v16_valid", 256'(out_valid), 256'(1));
    check("v16_busy_clear", 256'(busy), 256'(0));

    // vlen=6 masking, back-to-back with a vlen=0 vector
    sb.push_back(vector_rec(16'h0030, 16'h8A07, vec_of(6, 16'd1), 5'd6));
    beat(1, 0, 16'h0030, 16'h8A07, 5'd6, 16'd1, 16'd2, 16'd3, 16'd4);
    beat(1, 0, 16'h0030, 16'h8A07, 5'd0, 16'd5, 16'd6, 16'd7, 16'd8);
    check("v6_valid", 256'(out_valid), 256'(1));
    sb.push_back(vector_rec(16'h0034, 16'h8101, 256'(0), 5'd0));
    beat(1, 0, 16'h0034, 16'h8101, 5'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    check("v0_valid", 256'(out_valid), 256'(1));
    check("v0_busy", 256'(busy), 256'(0));

    // vlen=6 with a bubble between beats
    sb.push_back(vector_rec(16'h0032, 16'h8A07, vec_of(6, 16'd1), 5'd6));
    beat(1, 0, 16'h0032, 16'h8A07, 5'd6, 16'd1, 16'd2, 16'd3, 16'd4);
    idle();
    check("bubble_no_valid", 256'(out_valid), 256'(0));
    check("bubble_busy", 256'(busy), 256'(1));
    beat(1, 0, 16'h0032, 16'h8A07, 5'd0, 16'd5, 16'd6, 16'd7, 16'd8);
    check("bubble_valid", 256'(out_valid), 256'(1));

    // Flush mid-collection, then flush on what would be the final beat
    beat(1, 0, 16'h0050, 16'h8202, 5'd12, 16'd1, 16'd2, 16'd3, 16'd4);
    beat(1, 1, 16'h0050, 16'h8202, 5'd0, 16'd5, 16'd6, 16'd7, 16'd8);
    check("flush_no_valid", 256'(out_valid), 256'(0));
    check("flush_busy", 256'(busy), 256'(0));
    sb.push_back(scalar_rec(16'h0052, 16'h0124, 16'h1234));
    beat(1, 0, 16'h0052, 16'h0124, 5'd0, 16'h1234, 16'h0, 16'h0, 16'h0);
    check("post_flush_scalar", 256'(out_valid), 256'(1));
    beat(1, 0, 16'h0054, 16'h8303, 5'd8, 16'd1, 16'd2, 16'd3, 16'd4);
    beat(1, 1, 16'h0054, 16'h8303, 5'd0, 16'd5, 16'd6, 16'd7, 16'd8);
    check("flush_final_no_valid", 256'(out_valid), 256'(0));
    check("flush_final_busy", 256'(busy), 256'(0));

    // pc mismatch while collecting: err pulse, scalar emitted, vector dropped
    beat(1, 0, 16'h0040, 16'h8303, 5'd8, 16'd1, 16'd2, 16'd3, 16'd4);
    sb.push_back(scalar_rec(16'h0042, 16'h0045, 16'h5555));
    beat(1, 0, 16'h0042, 16'h0045, 5'd0, 16'h5555, 16'h0, 16'h0, 16'h0);
    check("err_pulse", 256'(err), 256'(1));
    check("err_scalar_valid", 256'(out_valid), 256'(1));
    check("err_busy", 256'(busy), 256'(0));
    idle();
    check("err_pulse_end", 256'(err), 256'(0));

    // vlen above 16 saturates to 16 (4 beats)
    sb.push_back(vector_rec(16'h0060, 16'h8F0A, vec_of(16, 16'h0100), 5'd16));
    for (int b = 0; b < 4; b++)
      beat(1, 0, 16'h0060, 16'h8F0A, 5'd20, 16'h0100 + 16'(4*b), 16'h0101 + 16'(4*b),
           16'h0102 + 16'(4*b), 16'h0103 + 16'(4*b));
    check("sat_valid", 256'(out_valid), 256'(1));

    // Dot-product opcode: reduced sum when enabled, ordinary vector otherwise
    begin
      rec_t r;
`ifdef VECTOR_COALESCE_VDOT_REDUCE_EN
      r = scalar_rec(16'h0070, 16'hE00B, 16'd20);
`else
      logic [255:0] v;
      v = vec_of(4, 16'd1);
      v[255-16*4 -: 16] = 16'd10;
      r = vector_rec(16'h0070, 16'hE00B, v, 5'd5);
`endif
      sb.push_back(r);
    end
    beat(1, 0, 16'h0070, 16'hE00B, 5'd5, 16'd1, 16'd2, 16'd3, 16'd4);
    beat(1, 0, 16'h0070, 16'hE00B, 5'd0, 16'd10, 16'd99, 16'd99, 16'd99);
    check("vdot_valid", 256'(out_valid), 256'(1));

    // Asynchronous reset mid-collection
    beat(1, 0, 16'h0080, 16'h8004, 5'd8, 16'd1, 16'd2, 16'd3, 16'd4);
    check("pre_reset_busy", 256'(busy), 256'(1));
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", 256'(busy), 256'(0));
    check("async_reset_pc", 256'(out_pc), 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    sb.push_back(scalar_rec(16'h0090, 16'h0016, 16'hBEEF));
    beat(1, 0, 16'h0090, 16'h0016, 5'd0, 16'hBEEF, 16'h0, 16'h0, 16'h0);
    check("post_reset_scalar", 256'(out_valid), 256'(1));

    repeat (4) idle();
    check("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
